// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one power-of-two stage per clock, largest stage first.
// The result register updates only on the final stage edge, alongside a one-cycle done pulse.
module shift_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] ModeSrl = 2'b00;
  localparam logic [1:0] ModeSll = 2'b01;
  localparam logic [1:0] ModeSra = 2'b10;
  localparam logic [SHW-1:0] KTop = SHW'(SHW - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   k_q, k_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SHW-1:0]   stage_amt;
  logic [WIDTH-1:0] stage_val;

  // Value of the working register after the stage selected by k_q.
  always_comb begin
    stage_amt = SHW'(1) << k_q;
    stage_val = work_q;
    if (mode_q == 2'b11) begin
      stage_val = '0;
    end else if (shamt_q[k_q]) begin
      unique case (mode_q)
        ModeSrl: stage_val = work_q >> stage_amt;
        ModeSll: stage_val = work_q << stage_amt;
        ModeSra: stage_val = WIDTH'($signed(work_q) >>> stage_amt);
        default: stage_val = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    k_d      = k_q;
    shamt_d  = shamt_q;
    mode_d   = mode_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          work_d  = in_data;
          shamt_d = shamt;
          mode_d  = mode;
          k_d     = KTop;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        work_d = stage_val;
        if (k_q == '0) begin
          result_d = stage_val;
          state_d  = StDone;
        end else begin
          k_d = k_q - SHW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      work_q   <= '0;
      result_q <= '0;
      k_q      <= KTop;
      shamt_q  <= '0;
      mode_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      k_q      <= k_d;
      shamt_q  <= shamt_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer: a driver pushes expected results and completion
// cycles into a scoreboard queue; a monitor checks done/busy/result every cycle.
module tb_shift_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   shamt;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  shift_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in_data(in_data),
    .shamt  (shamt),
    .mode   (mode),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               done_cyc;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  int               last_done = 0;
  int               vectors = 0;
  int               miscompares = 0;
  logic [WIDTH-1:0] held_result = '0;
  bit               monitor_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d,
                                             input int s, input logic [1:0] m);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    case (m)
      2'b00:   return d >> s;
      2'b01:   return d << s;
      2'b10:   return sd >>> s;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (monitor_on) begin
      logic exp_done, exp_busy;
      while (sb.size() > 0 && sb[0].done_cyc < cyc) begin
        check("missed_done", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
      exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].done_cyc - SHW) && (cyc < sb[0].done_cyc);
      check("done", 32'(done), 32'(exp_done));
      check("busy", 32'(busy), 32'(exp_busy));
      if (exp_done) begin
        held_result = sb[0].res;
        void'(sb.pop_front());
      end
      check("result", result, held_result);
    end
  end

  // Drive a request at a falling edge; assumes the DUT can accept on the next edge.
  task automatic issue(input logic [WIDTH-1:0] d, input int s, input logic [1:0] m,
                       input bit hold);
    exp_t e;
    in_data = d;
    shamt   = SHW'(s);
    mode    = m;
    start   = 1'b1;
    e.res      = model(d, s, m);
    e.done_cyc = cyc + 1 + SHW;
    last_done  = e.done_cyc;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
    in_data = $urandom;
    shamt   = SHW'($urandom);
    mode    = 2'($urandom);
  endtask

  task automatic wait_free();
    while (cyc < last_done) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    start = 1'b0;
    sb.delete();
    held_result = '0;
    last_done   = 0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_data = '0; shamt = '0; mode = '0;
    @(negedge clk);
    monitor_on = 1'b1;
    do_reset(2);
    repeat (10) @(negedge clk);

    issue(32'h8000_0000, 4, 2'b10, 1'b0);  wait_free();
    issue(32'h0000_0001, 31, 2'b01, 1'b0); wait_free();
    issue(32'hF000_0000, 8, 2'b00, 1'b0);  wait_free();
    issue(32'h1234_5678, 0, 2'b00, 1'b0);  wait_free();
    issue(32'hFFFF_FFFF, 0, 2'b11, 1'b0);
    // A start pulsed mid-run must not produce a second done.
    @(negedge clk);
    start = 1'b1; in_data = 32'hDEAD_BEEF; shamt = 5'd3; mode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    wait_free();
    repeat (3) @(negedge clk);

    // Back-to-back with start held high.
    for (int i = 0; i < 8; i++) begin
      issue($urandom, $urandom_range(0, WIDTH - 1), 2'($urandom), (i != 7));
      wait_free();
    end
    repeat (2) @(negedge clk);

    // Reset on the third RUN cycle aborts the operation.
    issue(32'hAAAA_5555, 7, 2'b01, 1'b0);
    @(negedge clk);
    do_reset(1);
    repeat (8) @(negedge clk);
    issue(32'h0000_FF00, 8, 2'b00, 1'b0); wait_free();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue($urandom, $urandom_range(0, WIDTH - 1), 2'($urandom), $urandom_range(0, 1) == 1);
      wait_free();
      start = 1'b0;
    end

    repeat (SHW + 3) @(negedge clk);
    if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit for the ALU shift path. It accepts one shift request (value, shift amount, mode) and applies one power-of-two shift stage per clock, from the largest stage down to 1, using the same stage semantics as the combinational shift stages. It holds the result with a one-cycle `done` pulse. It sits between the decode/operand registers and the ALU result mux. It replaces a single-cycle barrel shifter where timing requires one stage per cycle.

## Interface
- `WIDTH`, 32, data width; must equal 2**`SHW`.
- `SHW`, 5, shift-amount width; number of stages.

- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request strobe; sampled only when state is IDLE or DONE.
- `in_data` input WIDTH: operand; sampled with an accepted `start`.
- `shamt` input SHW: shift amount 0..WIDTH-1; sampled with an accepted `start`.
- `mode` input 2: 00 SRL, 01 SLL, 10 SRA, 11 reserved (result zero); sampled with an accepted `start`.
- `busy` output 1: high while stages are executing.
- `done` output 1: one-cycle pulse; `result` is valid from this cycle on.
- `result` output WIDTH: registered shift result; held until the next accepted `start`.

## Operation
- States:
  - IDLE (reset state)
  - RUN: stage index `k` counts SHW-1 down to 0.
  - DONE
- Accept: in IDLE or DONE with `start`=1, on that edge:
  - load the working register with `in_data`;
  - latch `shamt` and `mode`;
  - set `k`=SHW-1;
  - go to RUN.
- `start` in RUN is ignored; no queueing.
- RUN, each edge: stage amount is 2**k.
  - If `shamt[k]`=1, the working register becomes the shifted value; otherwise it is unchanged.
    - SRL: logical right shift, zero fill.
    - SLL: left shift, zero fill.
    - SRA: right shift, filled with bit WIDTH-1 of the current working value.
  - If `k`=0, go to DONE; otherwise `k` decrements.
- Mode 11: working register forced to 0 on the first RUN edge, regardless of `shamt`. Still takes the full SHW cycles.
- Stage order (largest first) is mandatory. Any order gives the same result, but verification traces check the intermediate values.
- DONE lasts one cycle:
  - `done`=1;
  - then IDLE, unless `start` is accepted, which goes directly to RUN.
- `result` is driven from the working register only on the transition into DONE. It does not change during RUN.
- Width rules:
  - shifts by `shamt` ≥ WIDTH cannot occur (SHW bits);
  - `shamt`=0 gives `result`=`in_data` for modes 00/01/10.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, working register 0, `k`=SHW-1.
- `reset` dominates `start` and any state. Reset mid-RUN aborts the operation: no `done`, and `result` returns to 0.
- Latency: `start` accepted at edge T0, so `busy`=1 in cycles T0+1..T0+SHW.
  - The last stage executes on edge T0+SHW.
  - `done`=1 and the new `result` are visible in the cycle after edge T0+SHW.
  - With defaults, `done` is 6 cycles after the `start` cycle.
- Throughput: one request per SHW+1 cycles. Back-to-back: `start` held high during DONE is accepted with no idle cycle.
- `busy` and `done` are never both 1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset then idle: assert `reset` 2 cycles -> `busy`=0, `done`=0, `result`=0x00000000. `start`=0 for 10 cycles -> no change.
- SRA sign fill: `in_data`=0x80000000, `shamt`=4, `mode`=10 -> `done` 6 cycles after `start`, `result`=0xF8000000. `busy` is high for exactly 5 cycles.
- SLL/SRL extremes:
  - 0x00000001, `shamt`=31, `mode`=01 -> 0x80000000.
  - 0xF0000000, `shamt`=8, `mode`=00 -> 0x00F00000.
  - 0x12345678, `shamt`=0, `mode`=00 -> 0x12345678.
- Reserved mode and ignored start:
  - 0xFFFFFFFF, `shamt`=0, `mode`=11 -> 0x00000000.
  - A second `start` pulsed during RUN is ignored: exactly one `done`.
- Back-to-back: `start` held high continuously with new operands each accept -> `done` every 6 cycles, each `result` correct, `result` stable between `done` pulses.
- Reset mid-operation: `reset` on the third RUN cycle -> no `done`, `result`=0. Next request 0x0000FF00, `shamt`=8, `mode`=00 -> 0x000000FF.
